// File: rtl/filter_sequencer.sv
// filter_sequencer: steps filter_used through the active filter bank per window, collects MAC results into one packed beat.
// Optional build macro RELU_EN clamps negative results to zero at capture.
module filter_sequencer #(
  parameter int NUM_FILTERS = 4,
  parameter int ACC_W = 20,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(NUM_FILTERS),
  localparam int NW = $clog2(NUM_FILTERS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         win_valid,
  output logic                         win_ready,
  input  logic [NW-1:0]                cfg_num_filters,
  output logic [SEL_W-1:0]             filter_used,
  output logic                         mac_start,
  input  logic                         mac_done,
  input  logic [ACC_W-1:0]             mac_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FILTERS*ACC_W-1:0] out_data,
  output logic [NUM_FILTERS-1:0]       out_mask,
  output logic                         busy,
  output logic                         proto_err,
  output logic [CNT_W-1:0]             win_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [SEL_W-1:0] fu_q, fu_d;
  logic [NW-1:0] n_q, n_d;
  logic [NUM_FILTERS-1:0][ACC_W-1:0] data_q, data_d;
  logic [NUM_FILTERS-1:0] mask_q, mask_d;
  logic perr_q, perr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] res;
  logic last;
`ifdef RELU_EN
  assign res = mac_result[ACC_W-1] ? '0 : mac_result;
`else
  assign res = mac_result;
`endif
  assign last = (NW'(fu_q) + NW'(1)) == n_q;
  always_comb begin
    state_d = state_q;
    fu_d = fu_q;
    n_d = n_q;
    data_d = data_q;
    mask_d = mask_q;
    perr_d = perr_q | (mac_done && state_q != WAIT);
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (win_valid) begin
        // zero or oversize counts mean "whole bank"
        n_d = (cfg_num_filters == '0 || cfg_num_filters > NW'(NUM_FILTERS)) ? NW'(NUM_FILTERS) : cfg_num_filters;
        data_d = '0;
        mask_d = '0;
        fu_d = '0;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (mac_done) begin
        data_d[fu_q] = res;
        mask_d[fu_q] = 1'b1;
        fu_d = last ? fu_q : fu_q + 1'b1;
        state_d = last ? OUTPUT : ISSUE;
      end
      OUTPUT: if (out_ready) begin
        cnt_d = cnt_q + 1'b1;
        fu_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fu_q <= '0;
      n_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      perr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fu_q <= fu_d;
      n_q <= n_d;
      data_q <= data_d;
      mask_q <= mask_d;
      perr_q <= perr_d;
      cnt_q <= cnt_d;
    end
  end
  assign win_ready = state_q == IDLE && !rst;
  assign busy = state_q != IDLE;
  assign mac_start = state_q == ISSUE;
  assign out_valid = state_q == OUTPUT;
  assign filter_used = fu_q;
  assign out_data = data_q;
  assign out_mask = mask_q;
  assign proto_err = perr_q;
  assign win_count = cnt_q;
endmodule

// File: tb/tb_filter_sequencer.sv
// tb_filter_sequencer: directed windows with a scoreboard of expected beats and a MAC responder model.
module tb_filter_sequencer;
  localparam int NF = 4;
  localparam int AW = 20;
  localparam int CW = 16;
  logic clk = 0, rst = 1, win_valid = 0, mac_done = 0, out_ready = 0;
  logic [2:0] cfg = 0;
  logic [AW-1:0] mac_result = 0;
  logic win_ready, mac_start, out_valid, busy, proto_err;
  logic [1:0] filter_used;
  logic [NF*AW-1:0] out_data, snap;
  logic [NF-1:0] out_mask;
  logic [CW-1:0] win_count;
  int cyc = 0, acc_cyc = 0, errors = 0, checks = 0, lat = 1, ov_rel = -1;
  bit mac_en = 1;
  logic [NF*AW-1:0] exp_d[$];
  logic [NF-1:0] exp_m[$];
  logic [AW-1:0] rq[$];
  int st_cyc[$];
  int st_fu[$];

  filter_sequencer dut (
    .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(win_ready),
    .cfg_num_filters(cfg), .filter_used(filter_used), .mac_start(mac_start),
    .mac_done(mac_done), .mac_result(mac_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .busy(busy), .proto_err(proto_err), .win_count(win_count)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  task automatic chk(input string nm, input logic [NF*AW-1:0] act, input logic [NF*AW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input logic [2:0] c);
    int k = 0;
    st_cyc.delete(); st_fu.delete(); ov_rel = -1;
    win_valid = 1; cfg = c;
    while (!win_ready && k < 100) begin step(); k++; end
    chk("accept_ready", win_ready, 1);
    acc_cyc = cyc + 1;
    step();
    win_valid = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin step(); k++; end
    chk("idle_timeout", busy, 0);
  endtask

  // MAC model: answers each mac_start with mac_done lat cycles later
  initial forever begin
    if (mac_start === 1'b1 && mac_en) begin
      st_cyc.push_back(cyc - acc_cyc + 1);
      st_fu.push_back(int'(filter_used));
      repeat (lat) step();
      if (mac_en) begin
        mac_done = 1;
        mac_result = rq.size() > 0 ? rq.pop_front() : '0;
      end
      step();
      mac_done = 0;
    end else step();
  end

  initial forever begin
    @(negedge clk);
    if (out_valid === 1'b1 && ov_rel < 0) ov_rel = cyc - acc_cyc + 1;
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_d.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        chk("beat_data", out_data, exp_d.pop_front());
        chk("beat_mask", out_mask, exp_m.pop_front());
      end
    end
  end

  initial begin
    logic [AW-1:0] s0;
    rst = 1;
    repeat (3) step();
    chk("rst_win_ready", win_ready, 0);
    chk("rst_ctrl", {busy, proto_err, mac_start, out_valid, out_mask, filter_used}, 0);
    chk("rst_data", out_data, 0);
    rst = 0;
    repeat (5) step();
    chk("idle_win_ready", win_ready, 1);
    chk("idle_ctrl", {busy, proto_err, mac_start, out_valid, out_mask, filter_used}, 0);
    chk("idle_data_cnt", {out_data, win_count}, 0);

    lat = 1; out_ready = 1;
    rq = '{20'd100, 20'd200, 20'd300, 20'd400};
    exp_d.push_back({20'd400, 20'd300, 20'd200, 20'd100}); exp_m.push_back(4'b1111);
    run_window(0);
    wait_idle();
    chk("full_nstart", st_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("full_start_cyc", st_cyc[i], 2 * i + 1);
      chk("full_fu", st_fu[i], i);
    end
    chk("full_ov_cyc", ov_rel, 9);
    chk("full_count", win_count, 1);

    lat = 3;
    rq = '{20'd11, 20'd22};
    exp_d.push_back({20'd0, 20'd0, 20'd22, 20'd11}); exp_m.push_back(4'b0011);
    run_window(2);
    cfg = 4;
    wait_idle();
    chk("part_nstart", st_cyc.size(), 2);
    chk("part_start0", st_cyc[0], 1);
    chk("part_start1", st_cyc[1], 5);
    chk("part_ov_cyc", ov_rel, 9);
    chk("part_count", win_count, 2);

    lat = 1; out_ready = 0;
    rq = '{20'd55};
    exp_d.push_back({20'd0, 20'd0, 20'd0, 20'd55}); exp_m.push_back(4'b0001);
    run_window(1);
    for (int k = 0; k < 50 && !out_valid; k++) step();
    snap = out_data;
    chk("bp_data", snap, {20'd0, 20'd0, 20'd0, 20'd55});
    win_valid = 1; cfg = 1;
    rq.push_back(20'd66);
    exp_d.push_back({20'd0, 20'd0, 20'd0, 20'd66}); exp_m.push_back(4'b0001);
    repeat (10) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_stable", out_data, snap);
      chk("bp_no_accept", win_ready, 0);
    end
    out_ready = 1;
    step();
    chk("bp_back_idle", {win_ready, out_valid}, 2'b10);
    chk("bp_count", win_count, 3);
    st_cyc.delete(); st_fu.delete(); ov_rel = -1;
    acc_cyc = cyc + 1;
    step();
    win_valid = 0;
    chk("bp_second_busy", busy, 1);
    wait_idle();
    chk("bp_count2", win_count, 4);

    snap = out_data;
    step();
    mac_done = 1; mac_result = 20'd999;
    step();
    mac_done = 0;
    step();
    chk("perr_set", proto_err, 1);
    chk("perr_no_write", out_data, snap);
    lat = 5;
    rq = '{20'd1, 20'd2, 20'd3, 20'd4};
    run_window(4);
    step(); step();
    mac_en = 0; rst = 1;
    #1;
    chk("midrst_ctrl", {win_ready, busy, proto_err, mac_start, out_valid, out_mask, filter_used}, 0);
    chk("midrst_data_cnt", {out_data, win_count}, 0);
    repeat (6) step();
    rst = 0; rq.delete(); st_cyc.delete(); mac_en = 1;
    repeat (4) step();
    chk("midrst_no_start", st_cyc.size(), 0);
    chk("midrst_idle", {win_ready, busy, proto_err}, 3'b100);

    lat = 1; out_ready = 1;
    rq = '{20'hFFFFB, 20'd7};
`ifdef RELU_EN
    s0 = '0;
`else
    s0 = 20'hFFFFB;
`endif
    exp_d.push_back({20'd0, 20'd0, 20'd7, s0}); exp_m.push_back(4'b0011);
    run_window(2);
    wait_idle();
    chk("relu_count", win_count, 1);
    chk("sb_empty", exp_d.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/filter_sequencer.md
Name: filter_sequencer

Overview:
Controller that time-multiplexes the filter-bank select of the convolution datapath. For each accepted input window it steps filter_used through the active filters. For each filter it fires one MAC operation, waits for completion and captures the accumulator result. It then presents all per-filter results as one packed output beat with a valid/ready handshake. It sits between the window fetcher (upstream), the filter mux plus 3x3x3 MAC (controlled) and the activation/writeback stage (downstream).

Parameters:
NUM_FILTERS, 4, filters in the bank; must be >= 2; filter_used width is SEL_W = $clog2(NUM_FILTERS).
ACC_W, 20, MAC result width (signed, two's complement).
CNT_W, 16, width of the completed-window counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
win_valid  input  1  upstream window (3x3x3 patch) available at the MAC input.
win_ready  output  1  sequencer can accept a window.
cfg_num_filters  input  $clog2(NUM_FILTERS+1)  active filter count; sampled only at window accept.
filter_used  output  SEL_W  filter select to the filter mux.
mac_start  output  1  one-cycle pulse that starts a MAC pass with the current filter_used.
mac_done  input  1  MAC pass complete; mac_result is valid in the same cycle.
mac_result  input  ACC_W  MAC accumulator result.
out_valid  output  1  packed result beat valid.
out_ready  input  1  downstream accepts the beat.
out_data  output  NUM_FILTERS*ACC_W  slot f at bits [f*ACC_W +: ACC_W].
out_mask  output  NUM_FILTERS  bit f = 1 when slot f holds a real result.
busy  output  1  high in every state other than IDLE.
proto_err  output  1  sticky flag; set when mac_done arrives outside WAIT.
win_count  output  CNT_W  number of completed output handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset values (async assert, all outputs): state IDLE, win_ready=0 during reset and 1 in IDLE, filter_used=0, mac_start=0, out_valid=0, out_data=0, out_mask=0, busy=0, proto_err=0, win_count=0.
- Reset mid-operation: partial results are discarded and the FSM returns to IDLE. No further mac_start is issued.
- FSM states: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE: win_ready=1. On win_valid & win_ready:
  - latch n = cfg_num_filters; values of 0 or above NUM_FILTERS are saturated to NUM_FILTERS;
  - clear all slots and out_mask; set filter_used=0; go to ISSUE.
- ISSUE (exactly one cycle): mac_start=1; go to WAIT.
- WAIT:
  - filter_used is held stable from ISSUE through WAIT.
  - On mac_done: write the result into slot filter_used and set out_mask[filter_used].
  - If filter_used == n-1, go to OUTPUT. Otherwise increment filter_used and go to ISSUE.
  - There is no timeout; WAIT holds indefinitely.
- OUTPUT: out_valid=1; out_data and out_mask are held stable until the handshake. On out_ready:
  - increment win_count;
  - reset filter_used to 0;
  - go to IDLE (out_valid drops the next cycle).
- out_ready sampled while out_valid=0 is ignored.
- win_ready is 0 in every state except IDLE. A new window is never accepted in the same cycle as the output handshake (IDLE-only accept).
- mac_done in IDLE, ISSUE or OUTPUT: ignored (no slot write) and proto_err set. proto_err is cleared only by rst.
- Latency with a single-cycle MAC (mac_done in the cycle after mac_start), accept edge = cycle 0:
  - mac_start pulses in cycles 1, 3, ..., 2n-1;
  - out_valid first high in cycle 2n+1.
- Unused slots (index >= n) read 0.

Optional Feature:
RELU_EN:
- Defined: results with the sign bit set are written as 0 (ReLU applied at capture); out_mask is unaffected.
- Undefined: mac_result is stored unmodified.

Test Plan:
- Reset idle check: assert rst, release, hold 5 cycles with no stimulus -> win_ready=1, busy=0, filter_used=0, all other outputs 0.
- Full bank, 1-cycle MAC: cfg=0, one window, mac_result = 100,200,300,400 -> mac_start in cycles 1,3,5,7; filter_used = 0,1,2,3; out_valid in cycle 9; out_data slots = 100,200,300,400; out_mask=4'b1111; win_count=1 after out_ready.
- Partial bank with variable latency: cfg=2, mac_done 3 cycles after each start -> exactly 2 mac_start pulses; out_mask=4'b0011; slots 2 and 3 read 0; cfg changed mid-window has no effect.
- Backpressure: out_ready low for 10 cycles -> out_valid and out_data stable; win_ready=0 while win_valid is held high; window accepted only after the handshake and return to IDLE.
- Protocol error plus reset mid-op: pulse mac_done in IDLE -> proto_err=1, no slot write. Start a window, assert rst during WAIT -> all outputs at reset values and proto_err=0.
- RELU_EN build: mac_result = -5 and +7 with cfg=2 -> slots 0 and 7. Same stimulus without the macro -> slot 0 = 2^ACC_W-5.
